eight_queen_host: RTL
=====================

// Module: eight_queen_host
// PURPOSE
//  Host-side controller and result checker for the eight_queen solver; it is the solver's other end.
//  On a user go pulse it waits for the solver's ready, then pulses start. It times the solve, captures
//  the 8-byte solution burst from out_bus and checks it column by column. Reports pass or fail, an error
//  code and the solve cycle count, and keeps the captured board readable.
// PARAMETERS
//  N_Q            8          board size; fixed at 8, since each out_bus byte is one column
//  TIMEOUT_CYCLES 1_000_000  max cycles from start to first done before aborting
//  CYC_W          32         width of the solve cycle counter
// PORTS
//  clk          in   1      system clock, rising edge
//  user_reset   in   1      asynchronous, active-high reset
//  go           in   1      1-cycle request to run one solve; ignored while busy=1
//  ready        in   1      solver idle and able to accept start
//  done         in   1      high for exactly 8 consecutive cycles carrying the solution burst
//  out_bus      in   8      during done cycle k (k=0..7), one-hot row mask of queen in column k
//  start        out  1      1-cycle request to the solver
//  busy         out  1      high in every state except IDLE
//  result_valid out  1      1-cycle pulse when the result fields are final
//  solution_ok  out  1      1 = all 8 columns legal and no conflict (valid with result_valid, held after)
//  error_code   out  3      0 OK, 1 NOT_ONEHOT, 2 ROW_CONFLICT, 3 DIAG_CONFLICT, 4 SHORT_BURST, 5 TIMEOUT
//  solve_cycles out  CYC_W  cycles from start asserted to first done (saturates at all-ones)
//  rd_col       in   3      read address into the captured board
//  rd_row       out  3      row index of queen in column rd_col (combinational read, 0 if invalid)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, board, masks and counters cleared. Reset mid-run aborts immediately
//   and drops start the same instant. No result_valid is issued for an aborted run.
//  FSM states: IDLE -> WAIT_RDY -> START -> SOLVE -> CAPTURE -> REPORT -> IDLE.
//  IDLE: on go=1, clear error, masks, board and counters; go to WAIT_RDY.
//  WAIT_RDY: wait (unbounded) for ready=1, then go to START.
//  START: start=1 for exactly one cycle; cycle counter loads 1; go to SOLVE.
//  SOLVE: counter increments each cycle.
//   On done=1: capture column 0 from out_bus this cycle; go to CAPTURE with idx=1.
//   If the counter reaches TIMEOUT_CYCLES with no done: error=5, go to REPORT.
//  CAPTURE, done=1: capture column idx, then idx++. If idx==7, go to REPORT after the capture.
//  CAPTURE, done=0 before 8 bytes: error=4 (SHORT_BURST), go to REPORT.
//  Per-column check, in the capture cycle, for column c = the mask byte:
//   - popcount(mask)!=1 -> NOT_ONEHOT; the row is not recorded.
//   - Else r = index of the set bit. row_used[r] set -> ROW_CONFLICT.
//   - diag_a[r+c] or diag_b[r-c+7] set (15-bit masks) -> DIAG_CONFLICT.
//   - Then set row_used[r], diag_a[r+c], diag_b[r-c+7] and board[c]=r.
//  The first error is sticky; later errors never overwrite it. Capture still continues through the burst.
//  If one column hits several checks, priority is NOT_ONEHOT > ROW > DIAG.
//  REPORT: result_valid=1 for one cycle; solution_ok=(error_code==0); go to IDLE.
//   Results hold until the next accepted go.
//  Latency: result_valid arrives 1 cycle after the done cycle that carries column 7.
//  done already high in WAIT_RDY or START is ignored; the burst is only sampled from SOLVE onward.
// STRUCTURE
//  eight_queen_pkg: state encodings, ERR_* codes (3-bit), N_Q, DIAG_W=2*N_Q-1.
//  Sub-module eq_conflict_tracker: holds row_used, diag_a, diag_b and board[8] (3-bit each).
//   It takes (clear, push, col, mask) and returns the error code for that push.
//  The top level holds the FSM, the cycle counter and the output registers.
// TESTING
//  1 Legal board, rows 0,4,7,5,2,6,1,3 -> bytes 01,10,80,20,04,40,02,08; done 40 cycles after start.
//    -> solution_ok=1, error=0, solve_cycles=40, rd_col=2 gives rd_row=7.
//  2 Burst 01,01,... (rows 0,0) -> error=2 latched at column 1, solution_ok=0, result_valid exactly once.
//  3 Burst 01,02,... (rows 0,1 in adjacent columns) -> error=3.
//  4 Column 0 byte = 03 -> error=1, even if later columns also conflict.
//  5 TIMEOUT_CYCLES=20, done never asserted -> error=5 after 20 SOLVE cycles, start pulsed only once.
//  6 done falls after 5 bytes -> error=4.
//    Also: user_reset asserted mid-CAPTURE -> all outputs 0 at once; the next go runs a fresh solve cleanly.

Source files
------------

// File: rtl/eight_queen_pkg.sv
// Shared types and helpers for the eight_queen host controller.
// State encoding, error codes and board geometry.
package eight_queen_pkg;

  localparam int N_Q    = 8;
  localparam int DIAG_W = 2 * N_Q - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_START,
    S_SOLVE,
    S_CAPTURE,
    S_REPORT
  } state_t;

  typedef logic [2:0] err_t;

  localparam err_t ERR_OK         = 3'd0;
  localparam err_t ERR_NOT_ONEHOT = 3'd1;
  localparam err_t ERR_ROW        = 3'd2;
  localparam err_t ERR_DIAG       = 3'd3;
  localparam err_t ERR_SHORT      = 3'd4;
  localparam err_t ERR_TIMEOUT    = 3'd5;

  localparam logic [N_Q-1:0] MASK_ONE = 1;

  function automatic logic is_onehot(
    input logic [N_Q-1:0] m
  );
    return (m != '0) && ((m & (m - MASK_ONE)) == '0);
  endfunction

  function automatic logic [2:0] row_of(
    input logic [N_Q-1:0] m
  );
    row_of = '0;
    for (int i = 0; i < N_Q; i++)
      if (m[i]) row_of = 3'(i);
  endfunction

endpackage

// File: rtl/eight_queen_host_tracker.sv
// Conflict tracker: row/diagonal occupancy and the captured board.
// The error output describes the push currently on the inputs.
module eq_conflict_tracker
  import eight_queen_pkg::*;
(
  input  logic           clk,
  input  logic           user_reset,
  input  logic           clear,
  input  logic           push,
  input  logic [2:0]     col,
  input  logic [N_Q-1:0] mask,
  output err_t           err,
  input  logic [2:0]     rd_col,
  output logic [2:0]     rd_row
);

  logic [N_Q-1:0]    row_used;
  logic [DIAG_W-1:0] diag_a;
  logic [DIAG_W-1:0] diag_b;
  logic [2:0]        board [N_Q];

  logic       oh;
  logic [2:0] r;
  logic [3:0] da;
  logic [3:0] db;

  always_comb begin
    oh  = is_onehot(mask);
    r   = row_of(mask);
    da  = 4'(r) + 4'(col);
    db  = 4'(r) + 4'd7 - 4'(col);
    err = ERR_OK;
    if (!oh)
      err = ERR_NOT_ONEHOT;
    else if (row_used[r])
      err = ERR_ROW;
    else if (diag_a[da] || diag_b[db])
      err = ERR_DIAG;
  end

  always_ff @(posedge clk or posedge user_reset) begin
    if (user_reset) begin
      row_used <= '0;
      diag_a   <= '0;
      diag_b   <= '0;
      for (int i = 0; i < N_Q; i++)
        board[i] <= '0;
    end else if (clear) begin
      row_used <= '0;
      diag_a   <= '0;
      diag_b   <= '0;
      for (int i = 0; i < N_Q; i++)
        board[i] <= '0;
    end else if (push && oh) begin
      // conflicting queens are still recorded
      row_used[r] <= 1'b1;
      diag_a[da]  <= 1'b1;
      diag_b[db]  <= 1'b1;
      board[col]  <= r;
    end
  end

  assign rd_row = board[rd_col];

endmodule

// File: rtl/eight_queen_host.sv
// Host controller for the eight_queen solver: start handshake,
// solve timing, burst capture and legality report.
module eight_queen_host
  import eight_queen_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CYC_W          = 32
) (
  input  logic             clk,
  input  logic             user_reset,
  input  logic             go,
  input  logic             ready,
  input  logic             done,
  input  logic [7:0]       out_bus,
  output logic             start,
  output logic             busy,
  output logic             result_valid,
  output logic             solution_ok,
  output logic [2:0]       error_code,
  output logic [CYC_W-1:0] solve_cycles,
  input  logic [2:0]       rd_col,
  output logic [2:0]       rd_row
);

  localparam logic [CYC_W-1:0] TMO = CYC_W'(TIMEOUT_CYCLES);
  localparam logic [CYC_W-1:0] ONE = CYC_W'(1);

  state_t           state, state_d;
  logic [2:0]       idx, idx_d;
  logic [CYC_W-1:0] cnt, cnt_d;
  err_t             err_q, err_d;
  logic             ok_q, ok_d;

  logic       clear;
  logic       push;
  logic [2:0] col;
  err_t       trk_err;
  err_t       cand;

  eq_conflict_tracker u_trk (
    .clk        (clk),
    .user_reset (user_reset),
    .clear      (clear),
    .push       (push),
    .col        (col),
    .mask       (out_bus),
    .err        (trk_err),
    .rd_col     (rd_col),
    .rd_row     (rd_row)
  );

  assign col = (state == S_SOLVE) ? 3'd0 : idx;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    err_d   = err_q;
    ok_d    = ok_q;
    clear   = 1'b0;
    push    = 1'b0;
    cand    = ERR_OK;
    unique case (state)
      S_IDLE: if (go) begin
        clear   = 1'b1;
        err_d   = ERR_OK;
        ok_d    = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: if (ready) state_d = S_START;
      S_START: begin
        cnt_d   = ONE;
        state_d = S_SOLVE;
      end
      S_SOLVE: begin
        if (done) begin
          push    = 1'b1;
          cand    = trk_err;
          idx_d   = 3'd1;
          state_d = S_CAPTURE;
        end else if (cnt >= TMO) begin
          cand    = ERR_TIMEOUT;
          state_d = S_REPORT;
        end else if (cnt != '1) begin
          cnt_d = cnt + ONE;
        end
      end
      S_CAPTURE: begin
        if (done) begin
          push  = 1'b1;
          cand  = trk_err;
          idx_d = idx + 3'd1;
          if (idx == 3'd7) state_d = S_REPORT;
        end else begin
          cand    = ERR_SHORT;
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // first error of a run wins
    if (err_q == ERR_OK && cand != ERR_OK)
      err_d = cand;
    if (state_d == S_REPORT && state != S_REPORT)
      ok_d = (err_d == ERR_OK);
  end

  always_ff @(posedge clk or posedge user_reset) begin
    if (user_reset) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
      err_q <= ERR_OK;
      ok_q  <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      err_q <= err_d;
      ok_q  <= ok_d;
    end
  end

  assign start        = (state == S_START);
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_REPORT);
  assign solution_ok  = ok_q;
  assign error_code   = err_q;
  assign solve_cycles = cnt;

endmodule
